// File: rtl/jk_counter_arbiter_pkg.sv
// Shared types, defaults and the round-robin pick for jk_counter_arbiter.
package jk_counter_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_NREQ  = 2;
    localparam int unsigned MAX_NREQ  = 8;
    localparam int unsigned MAX_IDW   = 3;

    // First valid requester after last_id, wrapping at nreq; returns last_id if none valid.
    function automatic logic [MAX_IDW-1:0] rr_winner(
        input logic [MAX_NREQ-1:0] valid,
        input logic [MAX_IDW-1:0]  last_id,
        input int unsigned         nreq
    );
        logic                found;
        logic [MAX_IDW-1:0]  win;
        int unsigned         idx;
        found = 1'b0;
        win   = last_id;
        for (int unsigned s = 1; s <= MAX_NREQ; s++) begin
            idx = (32'(last_id) + s) % nreq;
            if (!found && (s <= nreq) && valid[MAX_IDW'(idx)]) begin
                found = 1'b1;
                win   = MAX_IDW'(idx);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/jk_en_counter.sv
// Synchronous up-counter built from JK flops (J=K toggle chain) with sync clear and enable.
module jk_en_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    // Bit k toggles when enabled and all lower bits are 1; clear forces J=0,K=1.
    always_comb begin
        logic w_carry;
        w_carry = i_en;
        w_t     = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_t[k]  = w_carry;
            w_carry = w_carry & r_q[k];
        end
        w_j = i_clr ? '0 : w_t;
        w_k = i_clr ? '1 : w_t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= (w_j & ~r_q) | (~w_k & r_q);
        end
    end

    assign o_cnt = r_q;

endmodule

// File: rtl/jk_counter_arbiter.sv
// Round-robin scheduler sharing one JK up-counter between NREQ interval requesters.
module jk_counter_arbiter
    import jk_counter_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREQ  = DEF_NREQ,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_req_len,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic                  i_tick_en,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic [IDW-1:0]        o_grant_id,
    output logic [WIDTH-1:0]      o_cnt,
    output logic [NREQ-1:0]       o_done,
    output logic                  o_aborted
);

    state_e              r_state;
    state_e              w_state_next;
    logic [WIDTH-1:0]    r_len_q;
    logic [IDW-1:0]      r_grant_id;
    logic [IDW-1:0]      r_last_id;
    logic                r_busy;
    logic [NREQ-1:0]     r_done;
    logic                r_aborted;

    logic [WIDTH-1:0]    w_cnt;
    logic [WIDTH-1:0]    w_sel_len;
    logic [IDW-1:0]      w_winner;
    logic [IDW-1:0]      w_grant_next;
    logic [NREQ-1:0]     w_ready;
    logic [NREQ-1:0]     w_done_vec;
    logic                w_hs;
    logic                w_cnt_en;
    logic                w_abort_take;

    assign w_winner = IDW'(rr_winner(MAX_NREQ'(i_req_valid), MAX_IDW'(r_last_id), NREQ));

    // Combinational one-hot ready to the winner; suppressed outside IDLE and during reset.
    always_comb begin
        w_ready   = '0;
        w_sel_len = '0;
        if (!rst && (r_state == ST_IDLE) && (|i_req_valid)) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (w_winner == IDW'(i)) begin
                    w_ready[i] = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_sel_len = i_req_len[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_hs = |(i_req_valid & w_ready);

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant_id;
        w_cnt_en     = 1'b0;
        w_abort_take = 1'b0;
        w_done_vec   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_grant_next = w_winner;
                    w_state_next = (w_sel_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort outranks a coincident terminal tick.
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                    w_abort_take = 1'b1;
                end else if (i_tick_en) begin
                    w_cnt_en = 1'b1;
                    if ((w_cnt + WIDTH'(1)) == r_len_q) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_done_vec[i] = (w_grant_next == IDW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_len_q    <= '0;
            r_grant_id <= '0;
            r_last_id  <= IDW'(NREQ - 1);
            r_busy     <= 1'b0;
            r_done     <= '0;
            r_aborted  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grant_id <= w_grant_next;
            if (w_hs) begin
                r_len_q   <= w_sel_len;
                r_last_id <= w_winner;
            end
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= (w_state_next == ST_DONE) ? w_done_vec : '0;
            r_aborted <= w_abort_take;
        end
    end

    jk_en_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_cnt_en),
        .i_clr (w_hs),
        .o_cnt (w_cnt)
    );

    assign o_req_ready = w_ready;
    assign o_busy      = r_busy;
    assign o_grant_id  = r_grant_id;
    assign o_cnt       = w_cnt;
    assign o_done      = r_done;
    assign o_aborted   = r_aborted;

endmodule

// File: tb/tb_jk_counter_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, random run against a transaction model.
module tb_jk_counter_arbiter;

    localparam int W = 4;
    localparam int N = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [W-1:0]   len0, len1;
    logic [N-1:0]   req_ready;
    logic           tick_en;
    logic           abort;
    logic           busy;
    logic           grant_id;
    logic [W-1:0]   cnt;
    logic [N-1:0]   done;
    logic           aborted;

    int n_checks = 0;
    int n_fail   = 0;

    jk_counter_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_req_len   ({len1, len0}),
        .o_req_ready (req_ready),
        .i_tick_en   (tick_en),
        .i_abort     (abort),
        .o_busy      (busy),
        .o_grant_id  (grant_id),
        .o_cnt       (cnt),
        .o_done      (done),
        .o_aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] valid;
        logic [3:0] l0, l1;
        logic       tick, abrt;
        logic [1:0] ready;
        logic [3:0] cnt;
        logic [1:0] done;
        logic       busy, aborted, grant;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] v, logic [3:0] a, logic [3:0] b, logic t, logic ab,
                                logic [1:0] r, logic [3:0] c, logic [1:0] d, logic bz,
                                logic ap, logic g);
        vec_t x;
        x.valid = v; x.l0 = a; x.l1 = b; x.tick = t; x.abrt = ab;
        x.ready = r; x.cnt = c; x.done = d; x.busy = bz; x.aborted = ap; x.grant = g;
        return x;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] v, input logic [3:0] a, input logic [3:0] b,
                          input logic t, input logic ab);
        req_valid = v; len0 = a; len1 = b; tick_en = t; abort = ab;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && busy; k++) step();
        chk("idle_timeout busy", busy, 0);
    endtask

    // Transaction-level reference: owner id (-1 = free) and ticks left in its interval.
    int m_owner, m_left, m_cnt, m_last, m_grant;
    bit m_ab;

    function automatic int pick(logic [1:0] v);
        for (int s = 1; s <= N; s++) begin
            int id;
            id = (m_last + s) % N;
            if (v[id]) return id;
        end
        return -1;
    endfunction

    task automatic model_cycle(input logic [1:0] v, input logic [3:0] a, input logic [3:0] b,
                               input logic t, input logic ab, output int rdy);
        int p;
        m_ab = 1'b0;
        rdy  = 0;
        if (m_owner < 0) begin
            p = pick(v);
            if (p >= 0) begin
                rdy     = 1 << p;
                m_owner = p;
                m_last  = p;
                m_grant = p;
                m_cnt   = 0;
                m_left  = (p == 0) ? int'(a) : int'(b);
            end
        end else if (m_left > 0) begin
            if (ab) begin
                m_owner = -1;
                m_ab    = 1'b1;
            end else if (t) begin
                m_cnt++;
                m_left--;
            end
        end else begin
            m_owner = -1;
        end
    endtask

    initial begin
        int kd;
        int rdy;
        logic [1:0] rv;
        logic [3:0] ra, rb;
        logic rt, rab;

        // Reset state with requests already pending
        rst = 1'b1;
        set_in(2'b11, 4'd1, 4'd1, 1'b1, 1'b0);
        #2;
        chk("rst cnt", cnt, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst aborted", aborted, 0);
        chk("rst ready", req_ready, 0);
        chk("rst grant", grant_id, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round robin 0,1,0,1 with len=1, then single len=3 request on requester 0
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(2'b11, 4'd1, 4'd1, 1, 0, 2'b01, 4'd0, 2'b00, 1, 0, 0));
            vecs.push_back(mk(2'b11, 4'd1, 4'd1, 1, 0, 2'b00, 4'd1, 2'b01, 1, 0, 0));
            vecs.push_back(mk(2'b11, 4'd1, 4'd1, 1, 0, 2'b00, 4'd1, 2'b00, 0, 0, 0));
            vecs.push_back(mk(2'b11, 4'd1, 4'd1, 1, 0, 2'b10, 4'd0, 2'b00, 1, 0, 1));
            vecs.push_back(mk(2'b11, 4'd1, 4'd1, 1, 0, 2'b00, 4'd1, 2'b10, 1, 0, 1));
            vecs.push_back(mk(2'b11, 4'd1, 4'd1, 1, 0, 2'b00, 4'd1, 2'b00, 0, 0, 1));
        end
        vecs.push_back(mk(2'b01, 4'd3, 4'd0, 1, 0, 2'b01, 4'd0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b00, 4'd3, 4'd0, 1, 0, 2'b00, 4'd1, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b00, 4'd3, 4'd0, 1, 0, 2'b00, 4'd2, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b00, 4'd3, 4'd0, 1, 0, 2'b00, 4'd3, 2'b01, 1, 0, 0));
        vecs.push_back(mk(2'b00, 4'd3, 4'd0, 1, 0, 2'b00, 4'd3, 2'b00, 0, 0, 0));

        foreach (vecs[i]) begin
            set_in(vecs[i].valid, vecs[i].l0, vecs[i].l1, vecs[i].tick, vecs[i].abrt);
            #1;
            chk($sformatf("v%0d ready", i), req_ready, vecs[i].ready);
            step();
            chk($sformatf("v%0d cnt", i), cnt, vecs[i].cnt);
            chk($sformatf("v%0d done", i), done, vecs[i].done);
            chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d aborted", i), aborted, vecs[i].aborted);
            chk($sformatf("v%0d grant", i), grant_id, vecs[i].grant);
        end

        // Reset mid-RUN at cnt=2, then requester 0 wins a simultaneous request
        set_in(2'b01, 4'd5, 4'd1, 1, 0);
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("midrst pre cnt", cnt, 2);
        req_valid = 2'b11;
        len0 = 4'd1;
        rst = 1'b1;
        #1;
        chk("midrst cnt", cnt, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst aborted", aborted, 0);
        chk("midrst ready", req_ready, 0);
        chk("midrst grant", grant_id, 0);
        step();
        rst = 1'b0;
        #1;
        chk("postrst ready", req_ready, 1);
        step();
        chk("postrst grant", grant_id, 0);
        req_valid = 2'b00;
        wait_idle();

        // len=0: done the next cycle, cnt stays 0, next handshake two cycles after
        set_in(2'b01, 4'd0, 4'd2, 1, 0);
        #1;
        chk("len0 ready", req_ready, 1);
        step();
        chk("len0 done", done, 1);
        chk("len0 cnt", cnt, 0);
        chk("len0 busy", busy, 1);
        req_valid = 2'b00;
        step();
        chk("len0 after busy", busy, 0);
        chk("len0 after done", done, 0);
        req_valid = 2'b10;
        #1;
        chk("len0 next ready", req_ready, 2);
        step();
        req_valid = 2'b00;
        wait_idle();

        // len=15: full range without wrap
        set_in(2'b01, 4'd15, 4'd0, 1, 0);
        step();
        req_valid = 2'b00;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("len15 cnt k%0d", k), cnt, k);
            chk($sformatf("len15 done k%0d", k), done, (k == 15) ? 1 : 0);
        end
        step();
        chk("len15 busy end", busy, 0);
        chk("len15 cnt end", cnt, 15);

        // tick_en on alternate cycles, len=4: done 8 cycles after first RUN cycle
        set_in(2'b01, 4'd4, 4'd0, 0, 0);
        step();
        req_valid = 2'b00;
        kd = -1;
        for (int k = 1; k <= 12; k++) begin
            tick_en = ((k % 2) == 0);
            step();
            if (kd < 0 && done != 0) kd = k;
            chk($sformatf("tog cnt k%0d", k), cnt, (k / 2 < 4) ? k / 2 : 4);
            if (k == 8) chk("tog done", done, 1);
        end
        chk("tog done cycle", kd, 8);
        tick_en = 1'b1;

        // Abort at cnt=2 of len=5
        set_in(2'b01, 4'd5, 4'd0, 1, 0);
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("abort pre cnt", cnt, 2);
        abort = 1'b1;
        step();
        chk("abort aborted", aborted, 1);
        chk("abort done", done, 0);
        chk("abort cnt", cnt, 2);
        chk("abort busy", busy, 0);
        abort = 1'b0;
        step();
        chk("abort aborted clr", aborted, 0);
        chk("abort done after", done, 0);
        chk("abort cnt held", cnt, 2);

        // Abort coinciding with terminal tick
        set_in(2'b01, 4'd2, 4'd0, 1, 0);
        step();
        req_valid = 2'b00;
        step();
        abort = 1'b1;
        step();
        chk("termab cnt", cnt, 1);
        chk("termab done", done, 0);
        chk("termab aborted", aborted, 1);
        chk("termab busy", busy, 0);
        abort = 1'b0;
        step();
        chk("termab done after", done, 0);

        // Abort in DONE ignored, abort in IDLE no effect
        set_in(2'b01, 4'd1, 4'd0, 1, 0);
        step();
        req_valid = 2'b00;
        step();
        chk("doneab done", done, 1);
        abort = 1'b1;
        step();
        chk("doneab aborted", aborted, 0);
        chk("doneab busy", busy, 0);
        step();
        chk("idleab aborted", aborted, 0);
        abort = 1'b0;

        // Randomized run against the transaction model
        rst = 1'b1;
        set_in(2'b00, 4'd0, 4'd0, 0, 0);
        step();
        rst = 1'b0;
        m_owner = -1; m_left = 0; m_cnt = 0; m_last = N - 1; m_grant = 0; m_ab = 1'b0;
        for (int c = 0; c < 500; c++) begin
            rv  = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            rb  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            rt  = ($urandom_range(0, 3) != 0);
            rab = ($urandom_range(0, 19) == 0);
            set_in(rv, ra, rb, rt, rab);
            #1;
            model_cycle(rv, ra, rb, rt, rab, rdy);
            chk($sformatf("rnd%0d ready", c), req_ready, rdy);
            step();
            chk($sformatf("rnd%0d cnt", c), cnt, m_cnt);
            chk($sformatf("rnd%0d busy", c), busy, (m_owner >= 0) ? 1 : 0);
            chk($sformatf("rnd%0d done", c), done, (m_owner >= 0 && m_left == 0) ? (1 << m_owner) : 0);
            chk($sformatf("rnd%0d aborted", c), aborted, m_ab ? 1 : 0);
            chk($sformatf("rnd%0d grant", c), grant_id, m_grant);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
